axi_rd_burst_checker: RTL and testbench
=======================================

# axi_rd_burst_checker

AXI4 read-side checker sitting downstream of the DDR4 (or `axi_mem_target` model) read port: it issues a fixed sequence of INCR read bursts and compares every returned 512-bit beat against the address-derived pattern the write generator deposited. It consumes the AR/R channels, counts beats and errors, and reports a pass/fail summary to the test controller. One burst is outstanding at a time.

## Interface
- `N_BURSTS`, 12: number of read bursts per run (1..65535)
- `BURST_LEN`, 64: beats per burst (1..256); ARLEN = BURST_LEN-1
- `BASE_ADDR`, 32'h0000_0000: byte address of first burst, 64-byte aligned
- `SEED`, 32'hA5A5_0000: pattern XOR key

Ports:
- `aclk` in 1: single clock
- `aresetn` in 1: asynchronous assert, active-low reset
- `en` in 1: run request, level-sensitive
- `m_axi_arready` in 1 / `m_axi_arvalid` out 1 / `m_axi_araddr` out 32 / `m_axi_arid` out 4 (const 0) / `m_axi_arlen` out 8 / `m_axi_arsize` out 3 (const 3'd6) / `m_axi_arburst` out 2 (const 2'b01)
- `m_axi_rvalid` in 1 / `m_axi_rready` out 1 / `m_axi_rdata` in 512 / `m_axi_rresp` in 2 / `m_axi_rlast` in 1
- `busy` out 1: run in progress
- `done` out 1: run complete, held until `en` low
- `err_cnt` out 32: mismatching beats, saturating
- `beat_cnt` out 32: beats received this run
- `rlast_err` out 1: sticky RLAST misplacement flag
- `first_err_addr` out 32: byte address of first failing beat

## Operation
- Expected beat at byte address A: sixteen copies of 32-bit word (A ^ SEED), word 0 in bits [31:0].
- Burst k address: BASE_ADDR + k*BURST_LEN*64; beat j adds j*64. 32-bit arithmetic, bit 31 forced to 0 (wraps modulo 2^31).
- FSM states:
  - IDLE: `en`=1 -> AR; clears burst index, beat_cnt, err_cnt, rlast_err, first_err_addr.
  - AR: `m_axi_arvalid`=1, address stable; on `arready` -> DATA.
  - DATA: `m_axi_rready`=1; burst ends on beat index BURST_LEN-1 (counted, not on RLAST); then -> AR with index+1, or -> DRAIN if last burst.
  - DRAIN: wait for compare pipeline to empty (2 cycles) -> DONE.
  - DONE: `done`=1; `en`=0 -> IDLE.
- Beat is in error if data != expected OR `rresp` != 2'b00 OR RLAST misplaced. RLAST misplaced = asserted before last beat, or absent on last beat; sets `rlast_err`; counts once per beat.
- `en` deasserted in AR/DATA/DRAIN is ignored; the run completes (no AXI abort), then DONE exits immediately since `en`=0.
- `err_cnt` saturates at 32'hFFFF_FFFF; `beat_cnt` wraps.

## Timing
- Reset values: arvalid 0, araddr BASE_ADDR, arlen BURST_LEN-1, rready 0, busy 0, done 0, err_cnt 0, beat_cnt 0, rlast_err 0, first_err_addr 0.
- All outputs registered. `arvalid` rises cycle after entering AR; stays high until handshake (no retraction).
- `rready` high throughout DATA, low elsewhere; beats accepted only on rvalid&rready.
- Compare pipeline: cycle 1 registers rdata/rresp/rlast + expected; cycle 2 updates err_cnt/first_err_addr. beat_cnt increments in cycle 1.
- AR issue for burst k+1 occurs the cycle after last beat of burst k (no overlap); pipeline runs concurrently.
- `done` rises 3 cycles after final beat handshake; `busy` = state in {AR, DATA, DRAIN}.
- Asynchronous reset mid-burst: all state cleared immediately; pending R beats after reset are not accepted (rready 0).

## Configuration
- `RD_CHK_ERR_LOG_EN` defined: `first_err_addr` latches address of first erroring beat of the run, never overwritten until IDLE clears it.
- Not defined: capture logic removed, `first_err_addr` tied to 32'h0; all other behaviour identical.

## Test plan
- Clean run, N_BURSTS=2, BURST_LEN=4, memory preloaded with pattern, arready/rvalid always 1 -> araddr 0x0 then 0x100, beat_cnt=8, err_cnt=0, rlast_err=0, done 3 cycles after last beat.
- Single corrupted word at byte 0x140 (bit 0 flipped) -> err_cnt=1, first_err_addr=0x140 (with macro) / 0x0 (without).
- RLAST asserted on beat 2 of 4 and missing on beat 3 -> rlast_err=1, err_cnt=2, burst still ends after 4 beats.
- Random arready/rvalid back-pressure (50% duty), rresp=2'b10 on one beat -> arvalid never drops before handshake, err_cnt=1, beat_cnt=8.
- Drop `en` mid-DATA -> run completes, done pulses ≥1 cycle then FSM returns to IDLE; `aresetn` low mid-burst -> all outputs at reset values within same cycle, rready=0.

Source files
------------

// File: rtl/axi_rd_burst_checker.sv
// axi_rd_burst_checker
// AXI4 read-side pattern checker. Issues N_BURSTS INCR bursts of BURST_LEN
// 64-byte beats starting at BASE_ADDR, one burst outstanding at a time, and
// compares every returned beat against sixteen copies of (address ^ SEED).
// Beat errors: data mismatch, non-OKAY RRESP, or RLAST on the wrong beat.
//
// Optional build macro: RD_CHK_ERR_LOG_EN
//   defined     -> first_err_addr captures the byte address of the first
//                  failing beat of the run
//   not defined -> capture logic removed, first_err_addr tied to zero
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for en; results of the previous run stay visible
// S_AR     | arvalid held high with a stable address until arready
// S_DATA   | rready high, beats counted; burst ends on the counted last beat
// S_DRAIN  | compare pipeline empties before done is raised
// S_DONE   | done high until en is released

module axi_rd_burst_checker #(
    parameter int          N_BURSTS  = 12,
    parameter int          BURST_LEN = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         en,
    input  logic         m_axi_arready,
    output logic         m_axi_arvalid,
    output logic [31:0]  m_axi_araddr,
    output logic [3:0]   m_axi_arid,
    output logic [7:0]   m_axi_arlen,
    output logic [2:0]   m_axi_arsize,
    output logic [1:0]   m_axi_arburst,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready,
    input  logic [511:0] m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rlast,
    output logic         busy,
    output logic         done,
    output logic [31:0]  err_cnt,
    output logic [31:0]  beat_cnt,
    output logic         rlast_err,
    output logic [31:0]  first_err_addr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_AR    = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [31:0] ADDR_MASK   = 32'h7FFF_FFFF;
    localparam logic [31:0] BASE_MASKED = BASE_ADDR & ADDR_MASK;
    localparam logic [31:0] BEAT_BYTES  = 32'd64;
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [15:0] LAST_BURST  = 16'(N_BURSTS - 1);
    // Three DRAIN cycles: two for the compare pipeline, one so that done
    // appears with the final counter values already settled.
    localparam logic [1:0]  DRAIN_LOAD  = 2'd2;

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic [7:0]   beats_left;
    logic [15:0]  bursts_left;
    logic [31:0]  beat_addr;
    logic [31:0]  next_beat_addr;
    logic [1:0]   drain_cnt;
    logic         beat_acc;
    logic         run_start;
    logic         burst_end;

    logic         s1_valid;
    logic [511:0] s1_data;
    logic [1:0]   s1_resp;
    logic         s1_rlast;
    logic         s1_last;
    logic [31:0]  s1_exp;
    logic         s1_rlast_bad;
    logic         beat_err;

    assign m_axi_arid    = 4'd0;
    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = 3'd6;
    assign m_axi_arburst = 2'b01;

    assign beat_acc       = m_axi_rvalid && m_axi_rready;
    assign run_start      = (state == S_IDLE) && en;
    assign burst_end      = beat_acc && (beats_left == 8'd0);
    assign next_beat_addr = (beat_addr + BEAT_BYTES) & ADDR_MASK;

    // Next-state decode; en is only looked at in IDLE and DONE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = S_AR;
            S_AR:    if (m_axi_arvalid && m_axi_arready) state_nxt = S_DATA;
            S_DATA:  if (burst_end) state_nxt = (bursts_left == 16'd0) ? S_DRAIN : S_AR;
            S_DRAIN: if (drain_cnt == 2'd0) state_nxt = S_DONE;
            S_DONE:  if (!en) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Handshake and status outputs registered from the next state so they line up with it
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            m_axi_arvalid <= (state_nxt == S_AR);
            m_axi_rready  <= (state_nxt == S_DATA);
            busy          <= (state_nxt == S_AR) || (state_nxt == S_DATA) || (state_nxt == S_DRAIN);
            done          <= (state_nxt == S_DONE);
        end
    end

    // Burst and beat sequencing: down-counters with terminal compare, running beat address
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi_araddr <= BASE_MASKED;
            beat_addr    <= BASE_MASKED;
            beats_left   <= LAST_BEAT;
            bursts_left  <= LAST_BURST;
            beat_cnt     <= 32'd0;
        end else if (run_start) begin
            m_axi_araddr <= BASE_MASKED;
            beat_addr    <= BASE_MASKED;
            beats_left   <= LAST_BEAT;
            bursts_left  <= LAST_BURST;
            beat_cnt     <= 32'd0;
        end else if (beat_acc) begin
            beat_cnt  <= beat_cnt + 32'd1;
            beat_addr <= next_beat_addr;
            if (beats_left == 8'd0) begin
                beats_left   <= LAST_BEAT;
                m_axi_araddr <= next_beat_addr;
                if (bursts_left != 16'd0) bursts_left <= bursts_left - 16'd1;
            end else begin
                beats_left <= beats_left - 8'd1;
            end
        end
    end

    // DRAIN timer, loaded on the final beat of the run
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            drain_cnt <= 2'd0;
        end else if ((state == S_DATA) && (state_nxt == S_DRAIN)) begin
            drain_cnt <= DRAIN_LOAD;
        end else if ((state == S_DRAIN) && (drain_cnt != 2'd0)) begin
            drain_cnt <= drain_cnt - 2'd1;
        end
    end

    // Compare stage 1: capture the accepted beat alongside its expected word
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_resp  <= 2'b00;
            s1_rlast <= 1'b0;
            s1_last  <= 1'b0;
            s1_exp   <= 32'd0;
        end else begin
            s1_valid <= beat_acc;
            if (beat_acc) begin
                s1_data  <= m_axi_rdata;
                s1_resp  <= m_axi_rresp;
                s1_rlast <= m_axi_rlast;
                s1_last  <= (beats_left == 8'd0);
                s1_exp   <= beat_addr ^ SEED;
            end
        end
    end

    assign s1_rlast_bad = s1_rlast != s1_last;
    assign beat_err     = s1_valid && ((s1_data != {16{s1_exp}}) || (s1_resp != 2'b00) || s1_rlast_bad);

    // Compare stage 2: error counter saturates, rlast_err is sticky for the run
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt   <= 32'd0;
            rlast_err <= 1'b0;
        end else if (run_start) begin
            err_cnt   <= 32'd0;
            rlast_err <= 1'b0;
        end else begin
            if (beat_err && (err_cnt != 32'hFFFF_FFFF)) err_cnt <= err_cnt + 32'd1;
            if (s1_valid && s1_rlast_bad) rlast_err <= 1'b1;
        end
    end

`ifdef RD_CHK_ERR_LOG_EN
    logic [31:0] s1_addr;
    logic        err_logged;

    // Byte address travels with the beat through stage 1
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)      s1_addr <= 32'd0;
        else if (beat_acc) s1_addr <= beat_addr;
    end

    // First failing address of the run is kept until the next run starts
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            first_err_addr <= 32'd0;
            err_logged     <= 1'b0;
        end else if (run_start) begin
            first_err_addr <= 32'd0;
            err_logged     <= 1'b0;
        end else if (beat_err && !err_logged) begin
            first_err_addr <= s1_addr;
            err_logged     <= 1'b1;
        end
    end
`else
    assign first_err_addr = 32'd0;
`endif

endmodule

// File: tb/tb_axi_rd_burst_checker.sv
// Directed bench for axi_rd_burst_checker with 2 bursts of 4 beats.
// A behavioural read slave serves the address pattern and can inject
// corruption, bad RRESP, misplaced RLAST and random handshake stalls.
module tb_axi_rd_burst_checker;

    localparam int          NB   = 2;
    localparam int          BL   = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SEED = 32'hA5A5_0000;
`ifdef RD_CHK_ERR_LOG_EN
    localparam logic [31:0] EXP_FE_140 = 32'h0000_0140;
`else
    localparam logic [31:0] EXP_FE_140 = 32'h0000_0000;
`endif

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         en = 1'b0;
    logic         m_axi_arready;
    logic         m_axi_arvalid;
    logic [31:0]  m_axi_araddr;
    logic [3:0]   m_axi_arid;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
    logic [511:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         busy;
    logic         done;
    logic [31:0]  err_cnt;
    logic [31:0]  beat_cnt;
    logic         rlast_err;
    logic [31:0]  first_err_addr;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // slave configuration
    bit          ar_bp = 0, r_bp = 0, corrupt_en = 0, resp_err_en = 0, slv_clear = 0;
    logic [31:0] corrupt_addr = 32'h0;
    int          resp_err_beat = 0;
    logic [15:0] rlast_flip = 16'h0;
    // slave state
    bit          r_active = 0, ar_hs_q = 0, r_hs_q = 0, arv_hold = 0;
    int          r_beat = 0, slv_beats = 0, arv_drop = 0, hs_cyc_q = 0, last_hs_cyc = 0;
    logic [31:0] r_addr = 32'h0, ar_addr_q = 32'h0, word;
    logic [31:0] ar_log[$];

    axi_rd_burst_checker #(.N_BURSTS(NB), .BURST_LEN(BL), .BASE_ADDR(BASE), .SEED(SEED)) dut (
        .aclk(aclk), .aresetn(aresetn), .en(en),
        .m_axi_arready(m_axi_arready), .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .busy(busy), .done(done), .err_cnt(err_cnt), .beat_cnt(beat_cnt),
        .rlast_err(rlast_err), .first_err_addr(first_err_addr)
    );

    initial forever #5 aclk = ~aclk;
    initial forever begin @(posedge aclk); cyc++; end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, test incomplete");
        $fatal(1, "watchdog");
    end

    // Read slave: acts on the negative edge; handshakes seen at the previous posedge are retired first
    initial begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        forever begin
            @(negedge aclk);
            if (slv_clear) begin
                r_active = 0; r_beat = 0; slv_beats = 0; ar_hs_q = 0; r_hs_q = 0;
                arv_hold = 0; arv_drop = 0; ar_log.delete(); slv_clear = 0;
            end else begin
                if (arv_hold && !m_axi_arvalid) arv_drop++;
                if (r_hs_q) begin
                    r_beat++; slv_beats++; last_hs_cyc = hs_cyc_q;
                    r_addr = (r_addr + 32'd64) & 32'h7FFF_FFFF;
                    if (r_beat == BL) r_active = 0;
                end
                if (ar_hs_q) begin
                    r_active = 1; r_beat = 0; r_addr = ar_addr_q; ar_log.push_back(ar_addr_q);
                end
            end
            m_axi_arready = ar_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_rvalid  = r_active && (r_bp ? 1'($urandom_range(0, 1)) : 1'b1);
            word = r_addr ^ SEED;
            m_axi_rdata = {16{word}};
            if (corrupt_en && r_addr == corrupt_addr) m_axi_rdata[0] = ~m_axi_rdata[0];
            m_axi_rresp = (resp_err_en && slv_beats == resp_err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast = (r_beat == BL - 1) ^ ((slv_beats < 16) ? rlast_flip[slv_beats] : 1'b0);
            ar_hs_q   = m_axi_arvalid && m_axi_arready;
            ar_addr_q = m_axi_araddr;
            arv_hold  = m_axi_arvalid && !m_axi_arready;
            r_hs_q    = m_axi_rvalid && m_axi_rready;
            hs_cyc_q  = cyc + 1;
        end
    end

    task automatic start_run();
        #1 slv_clear = 1;
        @(negedge aclk); #1;
        en = 1'b1;
        @(negedge aclk); #1;
    endtask

    task automatic wait_done(output bit to, output int done_cyc);
        to = 1; done_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin to = 0; done_cyc = cyc; break; end
            @(negedge aclk); #1;
        end
    endtask

    task automatic wait_beats(input int n, output bit to);
        to = 1;
        for (int i = 0; i < 3000; i++) begin
            if (beat_cnt >= 32'(n)) begin to = 0; break; end
            @(negedge aclk); #1;
        end
    endtask

    task automatic end_run();
        en = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        ar_bp = 0; r_bp = 0; corrupt_en = 0; resp_err_en = 0; rlast_flip = 16'h0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        #1;
        n_checks++; if (m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %0b want 0", m_axi_arvalid); end
        n_checks++; if (m_axi_araddr !== BASE) begin n_fail++; $display("FAIL rst_araddr: got %h want %h", m_axi_araddr, BASE); end
        n_checks++; if (m_axi_arlen !== 8'd3) begin n_fail++; $display("FAIL rst_arlen: got %0d want 3", m_axi_arlen); end
        n_checks++; if ({m_axi_arid, m_axi_arsize, m_axi_arburst} !== {4'd0, 3'd6, 2'b01}) begin
            n_fail++; $display("FAIL rst_ar_consts: got id=%0d size=%0d burst=%0d want 0 6 1", m_axi_arid, m_axi_arsize, m_axi_arburst); end
        n_checks++; if ({m_axi_rready, busy, done, rlast_err} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_flags: got rready=%0b busy=%0b done=%0b rlast_err=%0b want 0000", m_axi_rready, busy, done, rlast_err); end
        n_checks++; if ({err_cnt, beat_cnt, first_err_addr} !== 96'd0) begin
            n_fail++; $display("FAIL rst_counts: got err=%0d beats=%0d fe=%h want 0 0 0", err_cnt, beat_cnt, first_err_addr); end
        aresetn = 1'b1;
        @(negedge aclk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %0b want 0 with en low", busy); end
    endtask

    task automatic test_clean();
        bit to; int dc;
        start_run();
        n_checks++; if (m_axi_arvalid !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL clean_start: got arvalid=%0b busy=%0b want 1 1", m_axi_arvalid, busy); end
        wait_done(to, dc);
        n_checks++; if (to) begin n_fail++; $display("FAIL clean_done_timeout: done=%0b want 1", done); end
        n_checks++; if (ar_log.size() != 2) begin n_fail++; $display("FAIL clean_ar_count: got %0d want 2", ar_log.size()); end
        else begin
            n_checks++; if (ar_log[0] !== 32'h0) begin n_fail++; $display("FAIL clean_araddr0: got %h want 0", ar_log[0]); end
            n_checks++; if (ar_log[1] !== 32'h100) begin n_fail++; $display("FAIL clean_araddr1: got %h want 100", ar_log[1]); end
        end
        n_checks++; if (beat_cnt !== 32'd8) begin n_fail++; $display("FAIL clean_beat_cnt: got %0d want 8", beat_cnt); end
        n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL clean_err_cnt: got %0d want 0", err_cnt); end
        n_checks++; if (rlast_err !== 1'b0) begin n_fail++; $display("FAIL clean_rlast_err: got %0b want 0", rlast_err); end
        n_checks++; if (dc - last_hs_cyc != 3) begin n_fail++; $display("FAIL clean_done_latency: got %0d want 3", dc - last_hs_cyc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clean_busy_at_done: got %0b want 0", busy); end
        end_run();
    endtask

    task automatic test_corrupt();
        bit to; int dc;
        corrupt_en = 1; corrupt_addr = 32'h140;
        start_run();
        wait_done(to, dc);
        n_checks++; if (to) begin n_fail++; $display("FAIL corrupt_done_timeout: done=%0b want 1", done); end
        n_checks++; if (err_cnt !== 32'd1) begin n_fail++; $display("FAIL corrupt_err_cnt: got %0d want 1", err_cnt); end
        n_checks++; if (first_err_addr !== EXP_FE_140) begin n_fail++; $display("FAIL corrupt_first_err: got %h want %h", first_err_addr, EXP_FE_140); end
        n_checks++; if (beat_cnt !== 32'd8 || rlast_err !== 1'b0) begin
            n_fail++; $display("FAIL corrupt_beats: got beats=%0d rlast_err=%0b want 8 0", beat_cnt, rlast_err); end
        end_run();
    endtask

    task automatic test_rlast();
        bit to; int dc;
        rlast_flip = 16'b0000_0000_0000_1100;  // early RLAST on beat 2, none on beat 3 of burst 0
        start_run();
        wait_done(to, dc);
        n_checks++; if (to) begin n_fail++; $display("FAIL rlast_done_timeout: done=%0b want 1", done); end
        n_checks++; if (rlast_err !== 1'b1) begin n_fail++; $display("FAIL rlast_flag: got %0b want 1", rlast_err); end
        n_checks++; if (err_cnt !== 32'd2) begin n_fail++; $display("FAIL rlast_err_cnt: got %0d want 2", err_cnt); end
        n_checks++; if (beat_cnt !== 32'd8) begin n_fail++; $display("FAIL rlast_beat_cnt: got %0d want 8", beat_cnt); end
        n_checks++; if (ar_log.size() != 2 || ar_log[1] !== 32'h100) begin
            n_fail++; $display("FAIL rlast_burst_len: got %0d ARs want 2 with second at 100", ar_log.size()); end
        end_run();
    endtask

    task automatic test_back_pressure();
        bit to; int dc;
        ar_bp = 1; r_bp = 1; resp_err_en = 1; resp_err_beat = 5;  // beat 5 sits at 0x140
        start_run();
        wait_done(to, dc);
        n_checks++; if (to) begin n_fail++; $display("FAIL bp_done_timeout: done=%0b want 1", done); end
        n_checks++; if (arv_drop != 0) begin n_fail++; $display("FAIL bp_arvalid_drop: got %0d drops want 0", arv_drop); end
        n_checks++; if (err_cnt !== 32'd1) begin n_fail++; $display("FAIL bp_err_cnt: got %0d want 1", err_cnt); end
        n_checks++; if (beat_cnt !== 32'd8) begin n_fail++; $display("FAIL bp_beat_cnt: got %0d want 8", beat_cnt); end
        n_checks++; if (first_err_addr !== EXP_FE_140) begin n_fail++; $display("FAIL bp_first_err: got %h want %h", first_err_addr, EXP_FE_140); end
        n_checks++; if (dc - last_hs_cyc != 3) begin n_fail++; $display("FAIL bp_done_latency: got %0d want 3", dc - last_hs_cyc); end
        end_run();
    endtask

    task automatic test_en_drop();
        bit to; int dc;
        start_run();
        wait_beats(2, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL endrop_beat_timeout: beats=%0d want >=2", beat_cnt); end
        en = 1'b0;
        wait_done(to, dc);
        n_checks++; if (to) begin n_fail++; $display("FAIL endrop_done_timeout: done=%0b want 1", done); end
        n_checks++; if (beat_cnt !== 32'd8 || err_cnt !== 32'd0) begin
            n_fail++; $display("FAIL endrop_counts: got beats=%0d err=%0d want 8 0", beat_cnt, err_cnt); end
        @(negedge aclk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL endrop_idle: got done=%0b busy=%0b want 0 0", done, busy); end
        end_run();
    endtask

    task automatic test_reset_mid();
        bit to;
        start_run();
        wait_beats(2, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_beat_timeout: beats=%0d want >=2", beat_cnt); end
        #2 aresetn = 1'b0; en = 1'b0;
        #1;
        n_checks++; if ({m_axi_rready, m_axi_arvalid, busy, done} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_flags: got rready=%0b arvalid=%0b busy=%0b done=%0b want 0000", m_axi_rready, m_axi_arvalid, busy, done); end
        n_checks++; if (beat_cnt !== 32'd0 || m_axi_araddr !== BASE) begin
            n_fail++; $display("FAIL rstmid_state: got beats=%0d araddr=%h want 0 %h", beat_cnt, m_axi_araddr, BASE); end
        @(negedge aclk); #1;
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        n_checks++; if (m_axi_rready !== 1'b0 || beat_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_no_accept: got rready=%0b beats=%0d want 0 0", m_axi_rready, beat_cnt); end
        end_run();
        slv_clear = 1;
        @(negedge aclk); #1;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_corrupt();
        test_rlast();
        test_back_pressure();
        test_en_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
